// File: rtl/tc2sm_stream_if.sv
// Stream bundle for the two's complement to sign-magnitude converter:
// one input channel (raw word) and one output channel (sign, magnitude, saturation flag).
interface tc2sm_stream_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-2:0] out_mag;
  logic         out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_sat
  );
endinterface

// File: rtl/tc2sm_stream.sv
// Two-stage pipelined two's complement to sign-magnitude converter with a
// saturating count of clipped (most-negative) words delivered downstream.
module tc2sm_stream #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  tc2sm_stream_if.slave  s,
  input  logic           sat_clr,
  output logic [15:0]    sat_count
);
  // Handshake: a word moves on a rising edge when valid=1 and ready=1 on that
  // channel; valid never waits on ready, and payload is held while valid=1, ready=0.
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic         s1_valid;
  logic [N-1:0] s1_data;
  logic         s2_valid;
  logic         s2_sign;
  logic [N-2:0] s2_mag;
  logic         s2_sat;

  logic         s2_load;
  logic         s1_load;
  logic         conv_sign;
  logic         conv_sat;
  logic [N-2:0] neg_mag;
  logic [N-2:0] conv_mag;
  logic         sat_hs;

  always_comb begin
    s2_load   = !s2_valid || s.out_ready;
    s1_load   = !s1_valid || s2_load;
    conv_sign = s1_data[N-1];
    conv_sat  = (s1_data == MOST_NEG);
    // Low N-1 bits of 2^N - d equal the negated low bits modulo 2^(N-1).
    neg_mag   = {(N-1){1'b0}} - s1_data[N-2:0];
    if (conv_sat) begin
      conv_mag = {(N-1){1'b1}};
    end else if (conv_sign) begin
      conv_mag = neg_mag;
    end else begin
      conv_mag = s1_data[N-2:0];
    end
    sat_hs    = s2_valid && s.out_ready && s2_sat;
  end

  assign s.in_ready  = s1_load;
  assign s.out_valid = s2_valid;
  assign s.out_sign  = s2_sign;
  assign s.out_mag   = s2_mag;
  assign s.out_sat   = s2_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= s.in_valid;
      if (s.in_valid) begin
        s1_data <= s.in_data;
      end
    end
  end

  // Payload only reloads on a real word so out_* keep the last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
      s2_sat   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= conv_sign;
        s2_mag  <= conv_mag;
        s2_sat  <= conv_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 16'd0;
    end else if (sat_clr) begin
      sat_count <= 16'd0;
    end else if (sat_hs && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_tc2sm_stream.sv
// Directed bench for tc2sm_stream: hand-computed vectors checked through an
// expected-word queue plus immediate checks on latency, backpressure, counter and reset.
module tb_tc2sm_stream;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  tc2sm_stream_if #(.N(N)) ifc();

  tc2sm_stream #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (ifc),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  int          out_hs   = 0;
  logic        push_model = 1'b0;
  logic [16:0] exp_q[$];

  // Packed expected word: {sign, magnitude, sat}.
  function automatic logic [16:0] pk(logic sg, logic [14:0] m, logic st);
    return {sg, m, st};
  endfunction

  function automatic logic [16:0] conv_model(logic [15:0] d);
    int v;
    v = int'(d);
    if (v == 32768) return pk(1'b1, 15'h7FFF, 1'b1);
    if (v < 32768)  return pk(1'b0, d[14:0], 1'b0);
    v = 65536 - v;
    return pk(1'b1, v[14:0], 1'b0);
  endfunction

  function automatic logic [31:0] out_word();
    return {15'd0, ifc.out_sign, ifc.out_mag, ifc.out_sat};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: sample at negedge (record accept, score any output handshake),
  // then return 1 time unit after the rising edge so inputs can be changed.
  task automatic step(output logic acc);
    logic [16:0] e;
    @(negedge clk);
    acc = ifc.in_valid && ifc.in_ready;
    if (acc && push_model) exp_q.push_back(conv_model(ifc.in_data));
    if (ifc.out_valid && ifc.out_ready) begin
      out_hs++;
      chk("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_word", out_word(), {15'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  task automatic drain();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] s_words[6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8001};
  logic [16:0] s_exp[6]   = '{17'h00000, 17'h00002, 17'h10002, 17'h0FFFE, 17'h1FFFF, 17'h1FFFE};
  logic [15:0] b_words[4] = '{16'h0005, 16'hFFFB, 16'h1234, 16'hC000};
  logic [16:0] b_exp[4]   = '{17'h0000A, 17'h1000A, 17'h02468, 17'h18000};

  // ---------------- directed sequence ----------------
  initial begin
    logic a;
    int   base;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("reset_in_ready",  32'(ifc.in_ready),  32'd1);
    chk("reset_sat_count", 32'(sat_count),     32'd0);
    chk("reset_out_word",  out_word(),         32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boundary stream at full throughput; word appears two edges after the
    // accepting edge is counted as the first.
    ifc.out_ready = 1'b1;
    base = out_hs;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(s_exp[i]);
      ifc.in_valid = 1'b1;
      ifc.in_data  = s_words[i];
      step(a);
      chk("stream_accept", 32'(a), 32'd1);
      if (i == 0) chk("lat_edge1_out_valid", 32'(ifc.out_valid), 32'd0);
      if (i == 1) chk("lat_edge2_out_valid", 32'(ifc.out_valid), 32'd1);
    end
    ifc.in_valid = 1'b0;
    tick();
    tick();
    chk("stream_no_bubble", 32'(out_hs - base), 32'd6);
    chk("stream_q_empty",   32'(exp_q.size()),  32'd0);
    chk("stream_sat_count", 32'(sat_count),     32'd1);

    // Backpressure: two words fill the pipe, then input stalls and output holds.
    for (int i = 0; i < 4; i++) exp_q.push_back(b_exp[i]);
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = b_words[0];
    step(a);
    chk("bp_accept0", 32'(a), 32'd1);
    ifc.in_data = b_words[1];
    step(a);
    chk("bp_accept1", 32'(a), 32'd1);
    ifc.in_data = b_words[2];
    chk("bp_in_ready_low", 32'(ifc.in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(a);
      chk("bp_no_accept",  32'(a),             32'd0);
      chk("bp_out_valid",  32'(ifc.out_valid), 32'd1);
      chk("bp_out_stable", out_word(),         32'(b_exp[0]));
      chk("bp_in_ready",   32'(ifc.in_ready),  32'd0);
    end
    ifc.out_ready = 1'b1;
    step(a);
    chk("bp_accept2", 32'(a), 32'd1);
    ifc.in_data = b_words[3];
    step(a);
    chk("bp_accept3", 32'(a), 32'd1);
    drain();

    // Saturation counter: clear, then 0x8000 every cycle with a clear pulse
    // landing on a saturated handshake.
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr_idle", 32'(sat_count), 32'd0);
    push_model    = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'h8000;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sat_clr = (c == 10);
      step(a);
      if (c == 9)  chk("sat_before_clr", 32'(sat_count), 32'd8);
      if (c == 10) chk("sat_clr_wins",   32'(sat_count), 32'd0);
      if (c == 11) chk("sat_resume",     32'(sat_count), 32'd1);
    end
    sat_clr = 1'b0;
    for (int c = 0; c < 65533; c++) tick();
    chk("sat_near_top", 32'(sat_count), 32'h0000FFFE);
    tick();
    chk("sat_top", 32'(sat_count), 32'h0000FFFF);
    for (int c = 0; c < 4; c++) tick();
    chk("sat_hold_top", 32'(sat_count), 32'h0000FFFF);
    drain();
    push_model = 1'b0;

    // Reset with two words in flight, released mid-cycle.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'h0001;
    tick();
    ifc.in_data = 16'h0002;
    tick();
    ifc.in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(ifc.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_sat_count", 32'(sat_count),     32'd0);
    chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    chk("rst_out_word",  out_word(),         32'd0);
    exp_q.delete();
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'h1234;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk("post_rst_edge1_valid", 32'(ifc.out_valid), 32'd0);
    tick();
    chk("post_rst_edge2_valid", 32'(ifc.out_valid), 32'd1);
    chk("post_rst_word",        out_word(),         32'(pk(1'b0, 15'h1234, 1'b0)));
    exp_q.push_back(pk(1'b0, 15'h1234, 1'b0));
    drain();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
